// File: rtl/clk_en_pkg.sv
// clk_en_pkg
// Shared definitions for the clock-enable generator family.
//   DIV_*      : common divisors for a 40 MHz system clock
//   div_fill() : replicates one divisor into a packed per-channel vector,
//                channel 0 in the LSBs. Used to build the reset-time divisors.
package clk_en_pkg;

    localparam int unsigned DIV_1HZ            = 40_000_000;
    localparam int unsigned DIV_DEBOUNCE_100HZ = 400_000;
    localparam int unsigned DIV_SCAN_1KHZ      = 40_000;

    // Widest packed divisor vector the helper can build (8 channels x 32 bits).
    localparam int unsigned MAX_CH     = 8;
    localparam int unsigned MAX_W      = 32;
    localparam int unsigned MAX_PACK_W = MAX_CH * MAX_W;

    // The caller casts the result down to its own NUM_CH*CNT_W width.
    function automatic logic [MAX_PACK_W-1:0] div_fill(
        input int unsigned num_ch,
        input int unsigned cnt_w,
        input logic [31:0] div
    );
        logic [MAX_PACK_W-1:0] r;
        r = '0;
        for (int unsigned c = 0; c < num_ch; c++) begin
            r = r | (MAX_PACK_W'(div) << (c * cnt_w));
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_en_gen_chan.sv
// clk_en_gen_chan
// One clock-enable channel: a modulo-D counter with a registered 1-cycle
// tick and a square wave that toggles on every terminal count.
// Ports:
//   clk_40M : system clock
//   rst     : synchronous reset, active-high
//   en      : run enable; 0 holds cnt/sq and forces tick low
//   load    : divisor reload strobe; clears cnt, forces tick low
//   div     : divisor D (0 disables the channel)
//   tick    : 1-cycle enable pulse, once every D cycles
//   sq      : toggles on every tick, period 2D
module clk_en_chan #(
    parameter int CNT_W = 26
) (
    input  logic             clk_40M,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div,
    output logic             tick,
    output logic             sq
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    // Terminal count is tested as cnt+1 == D so that D == 0 never needs
    // a D-1 that would underflow.
    always_comb begin
        cnt_inc = cnt + CNT_W'(1);
    end

    // Priority: reset, reload, freeze, disabled channel, terminal count.
    // A reload coincident with terminal count drops that tick and toggle.
    always_ff @(posedge clk_40M) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else if (load) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!en) begin
            tick <= 1'b0;
        end else if (div == '0) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt_inc == div) begin
            cnt  <= '0;
            tick <= 1'b1;
            sq   <= ~sq;
        end else begin
            cnt  <= cnt_inc;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen
// NUM_CH independent clock-enable channels with runtime-programmable
// divisors, plus a display scan counter stepped by one channel's tick.
// All outputs are registered and live in the clk_40M domain; they are
// meant to be used as enables, never as clocks.
// Ports:
//   clk_40M  : system clock, 40 MHz
//   rst      : synchronous reset, active-high
//   en       : global run enable
//   div_load : 1-cycle strobe, latches div_in into the divisor registers
//   div_in   : packed new divisors, channel 0 in the LSBs
//   tick     : per-channel 1-cycle enable pulse
//   sq       : per-channel toggled square wave
//   scan     : display scan index
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 26,
    parameter int SCAN_W = 2,
    parameter int SCAN_CH = 1,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT =
        (NUM_CH*CNT_W)'(div_fill(NUM_CH, CNT_W, DIV_1HZ))
) (
    input  logic                    clk_40M,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    div_load,
    input  logic [NUM_CH*CNT_W-1:0] div_in,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       sq,
    output logic [SCAN_W-1:0]       scan
);

    logic [NUM_CH*CNT_W-1:0] div_reg;

    // Active divisors. Channels see the old value during the load cycle,
    // but they clear themselves on div_load, so the new period starts clean.
    always_ff @(posedge clk_40M) begin
        if (rst) begin
            div_reg <= DIV_INIT;
        end else if (div_load) begin
            div_reg <= div_in;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        clk_en_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk_40M (clk_40M),
            .rst     (rst),
            .en      (en),
            .load    (div_load),
            .div     (div_reg[i*CNT_W +: CNT_W]),
            .tick    (tick[i]),
            .sq      (sq[i])
        );
    end

    // Scan steps one cycle after the selected channel's registered tick.
    // It holds while frozen or reloading, like the rest of the channel state.
    always_ff @(posedge clk_40M) begin
        if (rst) begin
            scan <= '0;
        end else if (en && !div_load && tick[SCAN_CH]) begin
            scan <= scan + SCAN_W'(1);
        end
    end

endmodule
